// File: rtl/axi4_lite_reg_bank_if.sv
// AXI4-Lite slave bus bundle for axi4_lite_reg_bank.
// Ports: AW/W/B write channels and AR/R read channels; master/slave modports.
interface axi4_lite_reg_bank_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite register bank: NUM_REGS r/w regs, flop outputs, write strobes.
// Ports: S_AXI_ACLK, S_AXI_ARESET (async high), s_axi bus, reg_out, wr_pulse.
// Option: AXI_REG_WSTRB_EN enables byte-lane write strobes.
module axi4_lite_reg_bank #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESET,
  axi4_lite_reg_bank_if.slave            s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE, R_DATA
  } r_state_t;

  w_state_t r_wst, w_wnxt;
  r_state_t r_rst, w_rnxt;

  // Low until the first edge after reset so readies stay off in reset.
  logic                  r_rdy;
  logic [IW-1:0]         r_aidx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_wstrb;
  logic [1:0]            r_bresp;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_wr_pulse;

  logic                  w_awready;
  logic                  w_wready;
  logic                  w_arready;
  logic                  w_commit;
  logic                  w_lat_a;
  logic                  w_lat_d;
  logic                  w_ar_hs;
  logic [IW-1:0]         w_cidx;
  logic [DATA_WIDTH-1:0] w_cdata;
  logic [NB-1:0]         w_cstrb;
  logic                  w_cok;
  logic [DATA_WIDTH-1:0] w_wmask;
  logic [IW-1:0]         w_ridx;
  logic                  w_rok;
  logic [DATA_WIDTH-1:0] w_rmux;
  logic                  w_unused_addr;

  assign w_unused_addr = ^{s_axi.S_AXI_AWADDR[1:0],
                           s_axi.S_AXI_ARADDR[1:0]};

  always_comb begin
    w_wnxt    = r_wst;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_commit  = 1'b0;
    w_lat_a   = 1'b0;
    w_lat_d   = 1'b0;
    w_cidx    = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
    w_cdata   = s_axi.S_AXI_WDATA;
    w_cstrb   = s_axi.S_AXI_WSTRB;
    unique case (r_wst)
      W_IDLE: begin
        w_awready = r_rdy;
        w_wready  = r_rdy;
        if (r_rdy) begin
          if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
            w_commit = 1'b1;
            w_wnxt   = W_RESP;
          end else if (s_axi.S_AXI_AWVALID) begin
            w_lat_a = 1'b1;
            w_wnxt  = W_HAVE_A;
          end else if (s_axi.S_AXI_WVALID) begin
            w_lat_d = 1'b1;
            w_wnxt  = W_HAVE_D;
          end
        end
      end
      W_HAVE_A: begin
        w_wready = 1'b1;
        w_cidx   = r_aidx;
        if (s_axi.S_AXI_WVALID) begin
          w_commit = 1'b1;
          w_wnxt   = W_RESP;
        end
      end
      W_HAVE_D: begin
        w_awready = 1'b1;
        w_cdata   = r_wdata;
        w_cstrb   = r_wstrb;
        if (s_axi.S_AXI_AWVALID) begin
          w_commit = 1'b1;
          w_wnxt   = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) w_wnxt = W_IDLE;
      end
    endcase
  end

  assign w_cok = (32'(w_cidx) < NUM_REGS);

`ifdef AXI_REG_WSTRB_EN
  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < NB; b++)
      w_wmask[b*8 +: 8] = {8{w_cstrb[b]}};
  end
`else
  logic w_unused_strb;
  assign w_unused_strb = ^w_cstrb;
  assign w_wmask = '1;
`endif

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_wst      <= W_IDLE;
      r_rdy      <= 1'b0;
      r_aidx     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= 2'b00;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else begin
      r_wst <= w_wnxt;
      r_rdy <= 1'b1;
      if (w_lat_a) r_aidx <= w_cidx;
      if (w_lat_d) begin
        r_wdata <= s_axi.S_AXI_WDATA;
        r_wstrb <= s_axi.S_AXI_WSTRB;
      end
      if (w_commit)
        r_bresp <= w_cok ? 2'b00 : 2'b10;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_wr_pulse[i] <= w_commit && w_cok &&
                         (w_cidx == IW'(i));
        if (w_commit && w_cok && (w_cidx == IW'(i)))
          r_regs[i] <= (r_regs[i] & ~w_wmask) |
                       (w_cdata & w_wmask);
      end
    end
  end

  assign w_ridx = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign w_rok  = (32'(w_ridx) < NUM_REGS);

  always_comb begin
    w_rmux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_ridx == IW'(i)) w_rmux = r_regs[i];
  end

  always_comb begin
    w_rnxt    = r_rst;
    w_arready = 1'b0;
    w_ar_hs   = 1'b0;
    unique case (r_rst)
      R_IDLE: begin
        w_arready = r_rdy;
        if (r_rdy && s_axi.S_AXI_ARVALID) begin
          w_ar_hs = 1'b1;
          w_rnxt  = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) w_rnxt = R_IDLE;
      end
    endcase
  end

  // Sampled at the handshake edge, so a same-edge commit is not visible.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_rst   <= R_IDLE;
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else begin
      r_rst <= w_rnxt;
      if (w_ar_hs) begin
        r_rdata <= w_rok ? w_rmux : '0;
        r_rresp <= w_rok ? 2'b00 : 2'b10;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = w_awready;
  assign s_axi.S_AXI_WREADY  = w_wready;
  assign s_axi.S_AXI_BVALID  = (r_wst == W_RESP);
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = w_arready;
  assign s_axi.S_AXI_RVALID  = (r_rst == R_DATA);
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;
  assign wr_pulse            = r_wr_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Directed self-checking bench for axi4_lite_reg_bank.
// Drives the AXI4-Lite interface and checks regs, strobes and responses.
module tb_axi4_lite_reg_bank;
  logic clk = 1'b0;
  logic rst;
  logic [255:0] reg_out;
  logic [7:0]   wr_pulse;
  int checks = 0;
  int errors = 0;

  axi4_lite_reg_bank_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

  axi4_lite_reg_bank #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .NUM_REGS(8)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .s_axi        (bus.slave),
    .reg_out      (reg_out),
    .wr_pulse     (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [10:0] a,
                          input logic [31:0] d,
                          input logic [3:0]  s);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_WVALID  = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    tick();
    bus.S_AXI_BREADY  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    #7;
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin
      errors++;
      $display("FAIL rst_ready got %b exp 000",
        {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
    end
    checks++;
    if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP} !== 6'b0) begin
      errors++;
      $display("FAIL rst_resp got %b exp 0",
        {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP});
    end
    checks++;
    if (reg_out !== 256'h0 || wr_pulse !== 8'h0 || bus.S_AXI_RDATA !== 32'h0) begin
      errors++;
      $display("FAIL rst_regs got %h/%h exp 0", reg_out, wr_pulse);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.S_AXI_AWREADY !== 1'b0) begin
      errors++;
      $display("FAIL rel_awready got %b exp 0", bus.S_AXI_AWREADY);
    end
    tick();
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL post_rst_ready got %b exp 111",
        {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
    end
  endtask

  task automatic test_write_both();
    bus.S_AXI_AWADDR = 11'h004; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    checks++;
    if (wr_pulse !== 8'h02 || reg_out[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_commit got %h/%h exp 02/deadbeef", wr_pulse, reg_out[63:32]);
    end
    checks++;
    if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
      errors++;
      $display("FAIL wb_bresp got %b/%b exp 1/00", bus.S_AXI_BVALID, bus.S_AXI_BRESP);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    checks++;
    if (wr_pulse !== 8'h00 || bus.S_AXI_BVALID !== 1'b0) begin
      errors++;
      $display("FAIL wb_after got %h/%b exp 00/0", wr_pulse, bus.S_AXI_BVALID);
    end
  endtask

  task automatic test_w_before_aw();
    int pulses;
    bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b10) begin
      errors++;
      $display("FAIL hd_ready got %b exp 10", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
    end
    tick();
    checks++;
    if (wr_pulse !== 8'h00) begin
      errors++;
      $display("FAIL hd_nopulse got %h exp 00", wr_pulse);
    end
    bus.S_AXI_AWADDR = 11'h01C; bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (wr_pulse === 8'h80) pulses++;
      else if (wr_pulse !== 8'h00) pulses += 100;
      checks++;
      if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
        errors++;
        $display("FAIL hd_bhold%0d got %b/%b exp 1/00", i,
          bus.S_AXI_BVALID, bus.S_AXI_BRESP);
      end
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL hd_pulses got %0d exp 1", pulses);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    checks++;
    if (bus.S_AXI_BVALID !== 1'b0 || reg_out[255:224] !== 32'h12345678) begin
      errors++;
      $display("FAIL hd_reg7 got %b/%h exp 0/12345678",
        bus.S_AXI_BVALID, reg_out[255:224]);
    end
  endtask

  task automatic test_out_of_range();
    logic [255:0] exp_out;
    exp_out = {32'h12345678, 160'h0, 32'hDEADBEEF, 32'h0};
    bus.S_AXI_ARADDR = 11'h004; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    checks++;
    if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'hDEADBEEF
        || bus.S_AXI_RRESP !== 2'b00) begin
      errors++;
      $display("FAIL rd_r1 got %b/%h/%b exp 1/deadbeef/00",
        bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RRESP);
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_ARADDR = 11'h020; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    checks++;
    if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'h0
        || bus.S_AXI_RRESP !== 2'b10) begin
      errors++;
      $display("FAIL rd_oor got %b/%h/%b exp 1/0/10",
        bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RRESP);
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_AWADDR = 11'h020; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'hFFFFFFFF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    checks++;
    if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b10) begin
      errors++;
      $display("FAIL wr_oor_bresp got %b/%b exp 1/10",
        bus.S_AXI_BVALID, bus.S_AXI_BRESP);
    end
    checks++;
    if (wr_pulse !== 8'h00 || reg_out !== exp_out) begin
      errors++;
      $display("FAIL wr_oor_regs got %h/%h exp 00/%h", wr_pulse, reg_out, exp_out);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_wstrb();
    logic [31:0] exp_r2;
`ifdef AXI_REG_WSTRB_EN
    exp_r2 = 32'hFF00FF00;
`else
    exp_r2 = 32'h00000000;
`endif
    do_write(11'h008, 32'hFFFFFFFF, 4'hF);
    checks++;
    if (reg_out[95:64] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL strb_init got %h exp ffffffff", reg_out[95:64]);
    end
    bus.S_AXI_AWADDR = 11'h008; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h0; bus.S_AXI_WSTRB = 4'b0101;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WSTRB = 4'hF;
    checks++;
    if (reg_out[95:64] !== exp_r2 || wr_pulse !== 8'h04) begin
      errors++;
      $display("FAIL strb_merge got %h/%h exp %h/04", reg_out[95:64], wr_pulse, exp_r2);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_read_hold();
    do_write(11'h00C, 32'h11111111, 4'hF);
    bus.S_AXI_ARADDR = 11'h00C; bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_AWADDR = 11'h00C; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'h11111111
          || bus.S_AXI_ARREADY !== 1'b0) begin
        errors++;
        $display("FAIL rh_hold%0d got %b/%h/%b exp 1/11111111/0", i,
          bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_ARREADY);
      end
      tick();
      bus.S_AXI_BREADY = 1'b0;
    end
    checks++;
    if (reg_out[127:96] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rh_reg3 got %h exp a5a5a5a5", reg_out[127:96]);
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    checks++;
    if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL rh_idle got %b/%b exp 0/1", bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
    end
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    checks++;
    if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rh_new got %b/%h exp 1/a5a5a5a5", bus.S_AXI_RVALID, bus.S_AXI_RDATA);
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.S_AXI_AWADDR = 11'h010; bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_ARADDR = 11'h00C; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (reg_out !== 256'h0 || wr_pulse !== 8'h0 || bus.S_AXI_RDATA !== 32'h0) begin
      errors++;
      $display("FAIL mid_regs got %h/%h/%h exp 0", reg_out, wr_pulse, bus.S_AXI_RDATA);
    end
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
         bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL mid_ctl got %b exp 00000",
        {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
         bus.S_AXI_BVALID, bus.S_AXI_RVALID});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.S_AXI_WDATA = 32'h55555555; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    checks++;
    if (wr_pulse !== 8'h0 || bus.S_AXI_BVALID !== 1'b0 || reg_out !== 256'h0) begin
      errors++;
      $display("FAIL mid_nocommit got %h/%b/%h exp 00/0/0",
        wr_pulse, bus.S_AXI_BVALID, reg_out);
    end
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b10) begin
      errors++;
      $display("FAIL mid_state got %b exp 10", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
    end
  endtask

  initial begin
    test_reset();
    test_write_both();
    test_w_before_aw();
    test_out_of_range();
    test_wstrb();
    test_read_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_reg_bank.md
AXI4_LITE_REG_BANK -- requirements
Module: axi4_lite_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, AXI byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register and bus data width; only 32 is legal.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of read/write registers (1..256, 4*NUM_REGS <= 2**ADDR_WIDTH).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports: S_AXI_ACLK in 1 clock; S_AXI_ARESET in 1 async active-high reset.
REQ-006 SHALL have write ports: S_AXI_AWADDR in ADDR_WIDTH; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1; S_AXI_WDATA in DATA_WIDTH; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1; S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-007 SHALL have read ports: S_AXI_ARADDR in ADDR_WIDTH; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1; S_AXI_RDATA out DATA_WIDTH; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-008 SHALL have user ports: reg_out out NUM_REGS*DATA_WIDTH, register i on bits [i*32+31:i*32]; wr_pulse out NUM_REGS, one-cycle strobe per register written.

Function
REQ-009 SHALL decode register index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored; index >= NUM_REGS is out of range.
REQ-010 Write FSM SHALL have states W_IDLE, W_HAVE_A (address latched), W_HAVE_D (data latched), W_RESP.
REQ-011 W_IDLE: AWREADY=WREADY=1; AW only -> W_HAVE_A; W only -> W_HAVE_D; both same cycle -> commit, W_RESP.
REQ-012 W_HAVE_A: AWREADY=0, WREADY=1; W handshake -> commit, W_RESP. W_HAVE_D symmetric with AWREADY=1, WREADY=0.
REQ-013 Commit SHALL update the addressed register at the clock edge of the completing handshake and assert wr_pulse[index] for exactly the following cycle.
REQ-014 W_RESP: BVALID=1, AWREADY=WREADY=0; BVALID and BRESP held stable until BREADY; BVALID&BREADY -> W_IDLE.
REQ-015 BRESP SHALL be 2'b00 in range, 2'b10 (SLVERR) out of range; out-of-range writes change no register and pulse no wr_pulse.
REQ-016 Read FSM SHALL have states R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
REQ-017 AR handshake SHALL register RDATA/RRESP and enter R_DATA; RVALID rises the cycle after the handshake (latency 1).
REQ-018 RDATA/RRESP SHALL be held stable while RVALID=1 and RREADY=0; RVALID&RREADY -> R_IDLE; back-to-back reads cost two cycles each.
REQ-019 Out-of-range read SHALL return RDATA=0, RRESP=2'b10; in-range RRESP=2'b00.
REQ-020 Read and write channels SHALL operate independently; a read handshake in the same cycle as a commit to that register returns the pre-write value.
REQ-021 reg_out SHALL reflect register contents directly from flops, updated the cycle after commit.

Reset
REQ-022 Assertion of S_AXI_ARESET SHALL immediately force: all registers 0, reg_out 0, wr_pulse 0, W_IDLE, R_IDLE, BVALID=0, RVALID=0, BRESP=RRESP=0, RDATA=0.
REQ-023 Reset mid-transaction SHALL discard latched address/data and pending responses; no register write occurs.
REQ-024 During reset, AWREADY, WREADY, ARREADY SHALL be 0; they assert from the first clock edge after deassertion.

Configuration
REQ-025 With macro AXI_REG_WSTRB_EN defined, commit SHALL update only bytes whose WSTRB bit is 1; WSTRB=0 is an OKAY no-op that still pulses wr_pulse.
REQ-026 Without AXI_REG_WSTRB_EN, WSTRB SHALL be ignored and every commit writes all 32 bits.

Verification
REQ-027 AW+W same cycle addr 0x004 data 0xDEADBEEF -> reg_out[63:32]=0xDEADBEEF, wr_pulse=8'h02 one cycle, BVALID next cycle, BRESP=00.
REQ-028 W two cycles before AW (addr 0x01C, data 0x12345678), BREADY low 3 cycles -> BVALID held 3+ cycles, reg 7=0x12345678, single wr_pulse[7].
REQ-029 Read addr 0x020 (NUM_REGS=8) -> RRESP=10, RDATA=0; write 0x020 -> BRESP=10, no register or wr_pulse change.
REQ-030 With AXI_REG_WSTRB_EN: reg 2=0xFFFFFFFF, write 0x00000000 WSTRB=4'b0101 -> reg 2=0xFF00FF00; without macro -> 0x00000000.
REQ-031 Read reg 3 with RREADY low 4 cycles while writing 0xA5A5A5A5 to reg 3 -> RDATA holds old value stable; next read returns 0xA5A5A5A5.
REQ-032 Assert S_AXI_ARESET between AW handshake and W -> all outputs 0 asynchronously; subsequent W alone does not commit.
